// File: rtl/fifo_wr_skid_adapter.sv
// -----------------------------------------------------------------------------
// fifo_wr_skid_adapter
//
// Write-side adapter for a standard (non-FWFT) FIFO. An upstream valid/ready
// stream is accepted into a small skid buffer. A registered output stage then
// drives the FIFO write port.
//
// wr_ready_o comes only from registered occupancy state. As a result, there is
// no combinational path from fifo_full_i to wr_ready_o. Producers can meet
// timing into BRAM FIFOs even when the full flag arrives late in the cycle.
//
// Parameters
//   DATA_WIDTH : width of the data words
//   SKID_DEPTH : number of skid entries (a power of two, at least 2)
//   CNT_W      : occupancy counter width (derived; do not override)
//
// Ports
//   clk          : clock; all logic changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   flush_i      : synchronous flush; discards every held word
//   wr_valid_i   : upstream data valid
//   wr_data_i    : upstream data
//   wr_ready_o   : adapter can accept a word (registered)
//   fifo_full_i  : full flag from the downstream FIFO
//   fifo_wr_en_o : write strobe to the downstream FIFO
//   fifo_din_o   : write data to the downstream FIFO (registered)
//   level_o      : skid occupancy; the word in the output register is not counted
//
// Optional feature (define FIFO_WR_ADAPT_STATS_EN to enable):
//   stall_cnt_o  : counts cycles with out_valid & fifo_full_i; saturates at 0xFFFF
//   level_max_o  : high-water mark of the skid occupancy
//   Both outputs clear on reset and on flush_i.
// -----------------------------------------------------------------------------
module fifo_wr_skid_adapter #(
   parameter int DATA_WIDTH = 32,
   parameter int SKID_DEPTH = 4,
   parameter int CNT_W      = $clog2(SKID_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  wr_valid_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  wr_ready_o,
   input  logic                  fifo_full_i,
   output logic                  fifo_wr_en_o,
   output logic [DATA_WIDTH-1:0] fifo_din_o,
   output logic [CNT_W-1:0]      level_o
`ifdef FIFO_WR_ADAPT_STATS_EN
   ,
   output logic [15:0]           stall_cnt_o,
   output logic [CNT_W-1:0]      level_max_o
`endif
);

   localparam int              PTR_W    = $clog2(SKID_DEPTH);
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(SKID_DEPTH);

   // Skid storage has no reset. Only the control state below is reset.
   logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];

   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_level;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_wr_ready;

   logic                  w_push;
   logic                  w_wr_en;
   logic                  w_out_free;
   logic                  w_pop;
   logic                  w_bypass;
   logic                  w_store;
   logic [CNT_W-1:0]      w_level_next;

   always_comb begin
      w_push     = wr_valid_i & r_wr_ready;
      // Only combinational use of fifo_full_i. It never reaches wr_ready_o.
      w_wr_en    = r_out_valid & ~fifo_full_i & ~flush_i;
      w_out_free = ~r_out_valid | w_wr_en;

      // Older words in the skid always drain first. An incoming word may skip
      // the skid only when the skid is empty, so words are never reordered.
      w_pop      = w_out_free & (r_level != '0);
      w_bypass   = w_out_free & (r_level == '0) & w_push;
      w_store    = w_push & ~w_bypass;

      w_level_next = r_level;
      if (flush_i) begin
         w_level_next = '0;
      end else if (w_store && !w_pop) begin
         w_level_next = r_level + 1'b1;
      end else if (w_pop && !w_store) begin
         w_level_next = r_level - 1'b1;
      end
   end

   // Control state and the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_wr_ready  <= 1'b0;
      end else if (flush_i) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_out_valid <= 1'b0;
         r_wr_ready  <= 1'b1;
      end else begin
         r_level    <= w_level_next;
         // Ready comes from the next occupancy alone, never from the full flag.
         r_wr_ready <= (w_level_next != FULL_LVL);
         if (w_store) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem[r_rd_ptr];
         end else if (w_bypass) begin
            r_out_valid <= 1'b1;
            r_out_data  <= wr_data_i;
         end else if (w_out_free) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // Skid storage write port.
   always_ff @(posedge clk) begin
      if (w_store && !flush_i) begin
         r_mem[r_wr_ptr] <= wr_data_i;
      end
   end

   assign wr_ready_o   = r_wr_ready;
   assign fifo_wr_en_o = w_wr_en;
   assign fifo_din_o   = r_out_data;
   assign level_o      = r_level;

`ifdef FIFO_WR_ADAPT_STATS_EN
   logic [15:0]      r_stall_cnt;
   logic [CNT_W-1:0] r_level_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_level_max <= '0;
      end else if (flush_i) begin
         r_stall_cnt <= '0;
         r_level_max <= '0;
      end else begin
         if (r_out_valid && fifo_full_i && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         // Track the next level so the mark is current right after the edge
         // that sets it.
         if (w_level_next > r_level_max) begin
            r_level_max <= w_level_next;
         end
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign level_max_o = r_level_max;
`endif

endmodule

// File: tb/tb_fifo_wr_skid_adapter.sv
module tb_fifo_wr_skid_adapter;
   localparam int DW = 16;
   localparam int SD = 4;
   localparam int CW = $clog2(SD) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          flush_i = 1'b0;
   logic          wr_valid_i = 1'b0;
   logic [DW-1:0] wr_data_i = '0;
   logic          wr_ready_o;
   logic          fifo_full_i = 1'b0;
   logic          fifo_wr_en_o;
   logic [DW-1:0] fifo_din_o;
   logic [CW-1:0] level_o;
`ifdef FIFO_WR_ADAPT_STATS_EN
   logic [15:0]   stall_cnt_o;
   logic [CW-1:0] level_max_o;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference model. The adapter behaves as a strict FIFO that holds at most
   // SD+1 words: SD in the skid plus one in the output register. The output
   // register is occupied whenever any word is held.
   logic [DW-1:0] q[$];
   bit            m_rdy_en = 1'b0;

   always #5 clk = ~clk;

   fifo_wr_skid_adapter #(.DATA_WIDTH(DW), .SKID_DEPTH(SD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .wr_valid_i  (wr_valid_i),
      .wr_data_i   (wr_data_i),
      .wr_ready_o  (wr_ready_o),
      .fifo_full_i (fifo_full_i),
      .fifo_wr_en_o(fifo_wr_en_o),
      .fifo_din_o  (fifo_din_o),
      .level_o     (level_o)
`ifdef FIFO_WR_ADAPT_STATS_EN
      ,
      .stall_cnt_o (stall_cnt_o),
      .level_max_o (level_max_o)
`endif
   );

   function automatic bit m_ready();
      return m_rdy_en && (q.size() != SD + 1);
   endfunction

   function automatic int m_level();
      return (q.size() > 0) ? q.size() - 1 : 0;
   endfunction

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic f, input logic fl);
      wr_valid_i  = v;
      wr_data_i   = d;
      fifo_full_i = f;
      flush_i     = fl;
   endtask

   // Advances the model across the coming rising edge, using the inputs
   // currently driven.
   task automatic model_edge();
      bit push;
      bit wen;
      push = wr_valid_i && m_ready();
      wen  = (q.size() > 0) && !fifo_full_i && !flush_i;
      if (flush_i) begin
         q.delete();
      end else begin
         if (wen) void'(q.pop_front());
         if (push) q.push_back(wr_data_i);
      end
      m_rdy_en = 1'b1;
   endtask

   task automatic test_reset();
      drive(0, '0, 0, 0);
      rst_n = 1'b0;
      q.delete();
      m_rdy_en = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      n_vec++;
      if (wr_ready_o !== 1'b0 || fifo_wr_en_o !== 1'b0 || level_o !== '0 || fifo_din_o !== '0) begin
         n_err++;
         $display("FAIL reset_hold rdy=%b wen=%b lvl=%0d din=%h exp 0/0/0/0000",
                  wr_ready_o, fifo_wr_en_o, level_o, fifo_din_o);
      end
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (wr_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release_rdy got %b exp 0", wr_ready_o);
      end
      model_edge();
      @(negedge clk);
      #1;
      n_vec++;
      if (wr_ready_o !== 1'b1 || fifo_wr_en_o !== 1'b0 || level_o !== '0) begin
         n_err++;
         $display("FAIL reset_first_edge rdy=%b wen=%b lvl=%0d exp 1/0/0",
                  wr_ready_o, fifo_wr_en_o, level_o);
      end
      model_edge();
      $display("test_reset done");
   endtask

   task automatic test_streaming();
      int nxt = 1;
      int nwr = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         drive(nxt <= 16, DW'(nxt), 0, 0);
         #1;
         n_vec++;
         if (fifo_wr_en_o !== ((c >= 1) && (c <= 16))) begin
            n_err++;
            $display("FAIL stream_wen cyc=%0d got %b exp %b", c, fifo_wr_en_o, (c >= 1) && (c <= 16));
         end
         if (fifo_wr_en_o === 1'b1) begin
            n_vec++;
            if (fifo_din_o !== DW'(nwr + 1)) begin
               n_err++;
               $display("FAIL stream_din got %h exp %h", fifo_din_o, DW'(nwr + 1));
            end
            nwr++;
         end
         n_vec++;
         if (level_o !== '0 || wr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL stream_lvl_rdy lvl=%0d rdy=%b exp 0/1", level_o, wr_ready_o);
         end
         if (wr_valid_i && m_ready()) nxt++;
         model_edge();
      end
      n_vec++;
      if (nwr != 16) begin
         n_err++;
         $display("FAIL stream_count got %0d exp 16", nwr);
      end
      $display("test_streaming done writes=%0d", nwr);
   endtask

   task automatic test_backpressure();
      int k = 1;
      int nwr = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         drive(k <= 6, DW'(k), 1, 0);
         #1;
         n_vec++;
         if (fifo_wr_en_o !== 1'b0 || wr_ready_o !== m_ready() || level_o !== CW'(m_level())) begin
            n_err++;
            $display("FAIL bp_fill wen=%b rdy=%b lvl=%0d exp 0/%b/%0d",
                     fifo_wr_en_o, wr_ready_o, level_o, m_ready(), m_level());
         end
         if (wr_valid_i && m_ready()) k++;
         model_edge();
      end
      @(negedge clk);
      drive(1, DW'(k), 1, 0);
      #1;
      n_vec++;
      if (k != 6 || level_o !== CW'(4) || wr_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL bp_full accepted=%0d lvl=%0d rdy=%b exp 5/4/0", k - 1, level_o, wr_ready_o);
      end
      model_edge();
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         drive(k <= 6, DW'(k), 0, 0);
         #1;
         n_vec++;
         if (fifo_wr_en_o !== (q.size() > 0) || wr_ready_o !== m_ready() || level_o !== CW'(m_level())) begin
            n_err++;
            $display("FAIL bp_drain wen=%b rdy=%b lvl=%0d exp %b/%b/%0d",
                     fifo_wr_en_o, wr_ready_o, level_o, q.size() > 0, m_ready(), m_level());
         end
         if (fifo_wr_en_o === 1'b1) begin
            n_vec++;
            if (fifo_din_o !== DW'(nwr + 1)) begin
               n_err++;
               $display("FAIL bp_din got %h exp %h", fifo_din_o, DW'(nwr + 1));
            end
            nwr++;
         end
         if (wr_valid_i && m_ready()) k++;
         model_edge();
      end
      n_vec++;
      if (nwr != 6) begin
         n_err++;
         $display("FAIL bp_count got %0d exp 6", nwr);
      end
      $display("test_backpressure done writes=%0d", nwr);
   endtask

   task automatic test_random_full();
      int  sent = 0;
      int  nwr = 0;
      bit  fstate = 1'b0;
      bit  v;
      bit  f;
      logic r0;
      for (int c = 0; c < 20000 && nwr < 1000; c++) begin
         @(negedge clk);
         r0 = wr_ready_o;
         if ($urandom_range(0, 5) == 0) fstate = ~fstate;
         f = fstate ^ ($urandom_range(0, 9) == 0);
         v = (sent < 1000) && ($urandom_range(0, 3) != 0);
         drive(v, DW'($urandom), f, 0);
         #1;
         n_vec++;
         if (wr_ready_o !== r0 || wr_ready_o !== m_ready()) begin
            n_err++;
            $display("FAIL rnd_rdy cyc=%0d got %b before=%b exp %b", c, wr_ready_o, r0, m_ready());
         end
         n_vec++;
         if (level_o !== CW'(m_level()) || fifo_wr_en_o !== ((q.size() > 0) && !f)) begin
            n_err++;
            $display("FAIL rnd_lvl_wen cyc=%0d lvl=%0d wen=%b exp %0d/%b",
                     c, level_o, fifo_wr_en_o, m_level(), (q.size() > 0) && !f);
         end
         if (fifo_wr_en_o === 1'b1 && q.size() > 0) begin
            n_vec++;
            if (fifo_din_o !== q[0]) begin
               n_err++;
               $display("FAIL rnd_din cyc=%0d got %h exp %h", c, fifo_din_o, q[0]);
            end
            nwr++;
         end
         if (v && m_ready()) sent++;
         model_edge();
      end
      n_vec++;
      if (nwr != 1000 || q.size() != 0) begin
         n_err++;
         $display("FAIL rnd_count writes=%0d held=%0d exp 1000/0", nwr, q.size());
      end
      $display("test_random_full done writes=%0d", nwr);
   endtask

   task automatic test_flush();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(1, DW'(16'h0A00 + c), 1, 0);
         #1;
         n_vec++;
         if (wr_ready_o !== 1'b1 || fifo_wr_en_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_fill rdy=%b wen=%b exp 1/0", wr_ready_o, fifo_wr_en_o);
         end
         model_edge();
      end
      @(negedge clk);
      drive(1, 16'hBEEF, 0, 1);
      #1;
      n_vec++;
      if (fifo_wr_en_o !== 1'b0 || level_o !== CW'(2)) begin
         n_err++;
         $display("FAIL flush_cycle wen=%b lvl=%0d exp 0/2", fifo_wr_en_o, level_o);
      end
      model_edge();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         drive(0, '0, 0, 0);
         #1;
         n_vec++;
         if (fifo_wr_en_o !== 1'b0 || level_o !== '0 || wr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_after cyc=%0d wen=%b lvl=%0d rdy=%b din=%h exp 0/0/1",
                     c, fifo_wr_en_o, level_o, wr_ready_o, fifo_din_o);
         end
         model_edge();
      end
      $display("test_flush done");
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(1, DW'(16'h3300 + c), 1, 0);
         model_edge();
      end
      @(negedge clk);
      drive(0, '0, 0, 0);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (fifo_wr_en_o !== 1'b0 || level_o !== '0 || wr_ready_o !== 1'b0 || fifo_din_o !== '0) begin
         n_err++;
         $display("FAIL reset_async wen=%b lvl=%0d rdy=%b din=%h exp 0/0/0/0000",
                  fifo_wr_en_o, level_o, wr_ready_o, fifo_din_o);
      end
      q.delete();
      m_rdy_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (wr_ready_o !== 1'b0 || fifo_wr_en_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_release rdy=%b wen=%b exp 0/0", wr_ready_o, fifo_wr_en_o);
      end
      model_edge();
      @(negedge clk);
      #1;
      n_vec++;
      if (wr_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_rdy got %b exp 1", wr_ready_o);
      end
      model_edge();
      $display("test_reset_mid done");
   endtask

`ifdef FIFO_WR_ADAPT_STATS_EN
   task automatic test_stats();
      @(negedge clk);
      drive(0, '0, 0, 1);
      model_edge();
      @(negedge clk);
      drive(1, 16'h5A00, 1, 0);
      #1;
      n_vec++;
      if (stall_cnt_o !== 16'd0 || level_max_o !== '0) begin
         n_err++;
         $display("FAIL stats_clear stall=%0d max=%0d exp 0/0", stall_cnt_o, level_max_o);
      end
      model_edge();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         drive(1, DW'(16'h5A01 + c), 1, 0);
         model_edge();
      end
      @(negedge clk);
      drive(0, '0, 0, 0);
      #1;
      n_vec++;
      if (stall_cnt_o !== 16'd10 || level_max_o !== CW'(4)) begin
         n_err++;
         $display("FAIL stats_values stall=%0d max=%0d exp 10/4", stall_cnt_o, level_max_o);
      end
      model_edge();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         drive(0, '0, 0, 0);
         #1;
         if (fifo_wr_en_o === 1'b1 && q.size() > 0) begin
            n_vec++;
            if (fifo_din_o !== q[0]) begin
               n_err++;
               $display("FAIL stats_drain got %h exp %h", fifo_din_o, q[0]);
            end
         end
         model_edge();
      end
      $display("test_stats done");
   endtask
`endif

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_random_full();
      test_flush();
      test_reset_mid();
`ifdef FIFO_WR_ADAPT_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
